mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues data-memory requests, waits for the bus handshake,
// aligns load data and maintains the WB-stage pipeline registers.
module mem_access_unit #(
    parameter int DATA_W   = 32,
    parameter int RA_W     = 5,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   ALU_out_MEM,
    input  logic [DATA_W-1:0]   S3_MEM,
    input  logic [RA_W-1:0]     Rd_MEM,
    input  logic                d_load_enable_MEM,
    input  logic                d_write_enable_MEM,
    input  logic [1:0]          size_MEM,
    input  logic                unsigned_MEM,
    output logic [DATA_W-1:0]   d_address,
    output logic [DATA_W-1:0]   d_data_write,
    output logic                d_write_enable,
    output logic                d_read_enable,
    output logic [DATA_W/8-1:0] d_byte_en,
    input  logic [DATA_W-1:0]   d_data_read,
    input  logic                d_data_valid,
    output logic                stall_MEM,
    output logic [DATA_W-1:0]   ALU_out_MEM_backward,
    output logic [RA_W-1:0]     Rd_MEM_backward,
    output logic [RA_W-1:0]     Rd_WB,
    output logic                d_load_enable_WB,
    output logic [DATA_W-1:0]   result_WB,
    output logic [1:0]          exc_WB
);
    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t            state;
    logic [7:0]        wait_cnt;

    logic [DATA_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [1:0]        cap_size;
    logic              cap_uns;
    logic              cap_load;
    logic [RA_W-1:0]   cap_rd;

    logic [DATA_W-1:0] cur_addr;
    logic [DATA_W-1:0] cur_wdata;
    logic [1:0]        cur_size;
    logic              cur_uns;
    logic              cur_load;
    logic              cur_access;
    logic [RA_W-1:0]   cur_rd;

    logic [OFF_W-1:0]  off;
    logic              misaligned;
    logic              issue;
    logic              timeout;
    logic [BE_W-1:0]   be_raw;
    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] load_data;

    // While waiting, the request comes from the captured copy so the bus sees a stable access.
    always_comb begin
        cur_addr   = ALU_out_MEM;
        cur_wdata  = S3_MEM;
        cur_size   = size_MEM;
        cur_uns    = unsigned_MEM;
        cur_load   = d_load_enable_MEM;
        cur_access = d_load_enable_MEM | d_write_enable_MEM;
        cur_rd     = Rd_MEM;
        if (state == WAIT) begin
            cur_addr   = cap_addr;
            cur_wdata  = cap_wdata;
            cur_size   = cap_size;
            cur_uns    = cap_uns;
            cur_load   = cap_load;
            cur_access = 1'b1;
            cur_rd     = cap_rd;
        end
    end

    assign off = cur_addr[OFF_W-1:0];

    always_comb begin
        misaligned = 1'b0;
        case (cur_size)
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = cur_addr[0];
            2'b10:   misaligned = |cur_addr[1:0];
            default: misaligned = (DATA_W == 32) ? 1'b1 : |cur_addr[2:0];
        endcase
    end

    assign issue   = reset_n & cur_access & ~misaligned;
    assign timeout = reset_n && (state == WAIT) && !d_data_valid
                     && (wait_cnt == 8'(MAX_WAIT - 1));

    assign stall_MEM      = issue & ~d_data_valid & ~timeout;
    assign d_read_enable  = issue & cur_load;
    assign d_write_enable = issue & ~cur_load;
    assign d_address      = cur_addr & ~DATA_W'(BE_W - 1);

    always_comb begin
        be_raw       = '1;
        d_data_write = cur_wdata;
        case (cur_size)
            2'b00: begin
                be_raw       = BE_W'(1) << off;
                d_data_write = {BE_W{cur_wdata[7:0]}};
            end
            2'b01: begin
                be_raw       = BE_W'(3) << off;
                d_data_write = {(DATA_W/16){cur_wdata[15:0]}};
            end
            2'b10: begin
                be_raw       = BE_W'(15) << off;
                d_data_write = {(DATA_W/32){cur_wdata[31:0]}};
            end
            default: begin
                be_raw       = '1;
                d_data_write = cur_wdata;
            end
        endcase
    end

    assign d_byte_en = issue ? be_raw : '0;

    // Move the addressed lane down to bit 0, then extend according to the access size.
    always_comb begin
        shifted   = d_data_read >> {off, 3'b000};
        load_data = shifted;
        case (cur_size)
            2'b00: begin
                if (cur_uns) load_data = DATA_W'(shifted[7:0]);
                else         load_data = DATA_W'($signed(shifted[7:0]));
            end
            2'b01: begin
                if (cur_uns) load_data = DATA_W'(shifted[15:0]);
                else         load_data = DATA_W'($signed(shifted[15:0]));
            end
            2'b10: begin
                if (cur_uns) load_data = DATA_W'(shifted[31:0]);
                else         load_data = DATA_W'($signed(shifted[31:0]));
            end
            default: load_data = shifted;
        endcase
    end

    assign ALU_out_MEM_backward = ALU_out_MEM;
    assign Rd_MEM_backward      = d_load_enable_MEM ? '0 : Rd_MEM;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state            <= IDLE;
            wait_cnt         <= '0;
            Rd_WB            <= '0;
            d_load_enable_WB <= 1'b0;
            result_WB        <= '0;
            exc_WB           <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (stall_MEM) begin
                        state     <= WAIT;
                        wait_cnt  <= '0;
                        cap_addr  <= ALU_out_MEM;
                        cap_wdata <= S3_MEM;
                        cap_size  <= size_MEM;
                        cap_uns   <= unsigned_MEM;
                        cap_load  <= d_load_enable_MEM;
                        cap_rd    <= Rd_MEM;
                    end
                end
                WAIT: begin
                    if (d_data_valid || timeout) state <= IDLE;
                    else                         wait_cnt <= wait_cnt + 8'd1;
                end
            endcase

            // Faulting or stalled accesses leave a bubble; the exception flag lives for one cycle.
            if (stall_MEM) begin
                Rd_WB            <= '0;
                d_load_enable_WB <= 1'b0;
                exc_WB           <= 2'b00;
            end else if (timeout) begin
                Rd_WB            <= '0;
                d_load_enable_WB <= 1'b0;
                exc_WB           <= 2'b10;
            end else if (cur_access && misaligned) begin
                Rd_WB            <= '0;
                d_load_enable_WB <= 1'b0;
                exc_WB           <= 2'b01;
            end else begin
                Rd_WB            <= cur_rd;
                d_load_enable_WB <= cur_access & cur_load;
                result_WB        <= (cur_access && cur_load) ? load_data : cur_addr;
                exc_WB           <= 2'b00;
            end
        end
    end
endmodule
